// File: rtl/lvds_link_pkg.sv
`default_nettype none
// ============================================================================
// Module : lvds_link_pkg
// Desc   : Shared state encoding and constants for the LVDS link sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package lvds_link_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRAIN = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } link_state_t;

    localparam int RETRAIN_CNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lvds_link_ctrl
// Desc   : Link sequencer: sync training, partner hold-off, TX/RX gate scheduling.
// Rev    : 1.0 - initial release
// ============================================================================
module lvds_link_ctrl
    import lvds_link_pkg::*;
#(
    parameter int SYNC_HOLD_CYCLES = 256,
    parameter int LOCK_TIMEOUT     = 65535
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic                     i_sync_complete,
    output logic                     o_sync_generate,
    input  logic                     i_tx_pending,
    output logic                     o_tx_start,
    input  logic                     i_tx_done,
    output logic                     o_tx_grant,
    input  logic                     i_rx_available,
    input  logic                     i_rx_ready,
    output logic                     o_rx_pull,
    output logic                     o_link_up,
    output logic [2:0]               o_state,
    output logic                     o_lock_err,
    output logic [RETRAIN_CNT_W-1:0] o_retrain_cnt
);

    localparam int CNT_W = $clog2(max_int(SYNC_HOLD_CYCLES, LOCK_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] c_hold_last    = CNT_W'(SYNC_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);

    link_state_t              r_state;
    link_state_t              w_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_next;
    logic                     r_tx_busy;
    logic                     r_rx_holdoff;
    logic                     r_sync_generate;
    logic                     r_tx_start;
    logic                     r_rx_pull;
    logic                     r_link_up;
    logic                     r_lock_err;
    logic [RETRAIN_CNT_W-1:0] r_retrain_cnt;
    logic                     w_timeout;
    logic                     w_run_ok;
    logic                     w_tx_start;
    logic                     w_rx_pull;
    logic                     w_in_flight;

    // No new work is issued in the cycle RUN is being left.
    assign w_run_ok    = (r_state == RUN) && i_sync_complete && i_enable;
    assign w_tx_start  = w_run_ok && i_tx_pending && (!r_tx_busy || i_tx_done);
    assign w_rx_pull   = w_run_ok && i_rx_available && i_rx_ready && !r_rx_holdoff;
    // A done arriving on the exit cycle already retires the word, so DRAIN is skipped.
    assign w_in_flight = r_tx_busy && !i_tx_done;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable) w_next = TRAIN;
            end
            TRAIN: begin
                if (!i_enable)                   w_next = IDLE;
                else if (i_sync_complete)        w_next = HOLD;
                else if (r_cnt == c_timeout_last) w_timeout = 1'b1;
                else                             w_cnt_next = r_cnt + CNT_W'(1);
            end
            HOLD: begin
                if (!i_enable)                w_next = IDLE;
                else if (!i_sync_complete)    w_next = TRAIN;
                else if (r_cnt == c_hold_last) w_next = RUN;
                else                          w_cnt_next = r_cnt + CNT_W'(1);
            end
            RUN: begin
                if (!i_sync_complete) w_next = w_in_flight ? DRAIN : TRAIN;
                else if (!i_enable)   w_next = w_in_flight ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (i_tx_done) w_next = i_enable ? TRAIN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_tx_busy       <= 1'b0;
            r_rx_holdoff    <= 1'b0;
            r_sync_generate <= 1'b0;
            r_tx_start      <= 1'b0;
            r_rx_pull       <= 1'b0;
            r_link_up       <= 1'b0;
            r_lock_err      <= 1'b0;
            r_retrain_cnt   <= '0;
        end else begin
            r_state         <= w_next;
            r_cnt           <= w_cnt_next;
            r_sync_generate <= (w_next == TRAIN) || (w_next == HOLD);
            r_link_up       <= (w_next == RUN);
            r_tx_start      <= w_tx_start;
            r_rx_pull       <= w_rx_pull;
            r_rx_holdoff    <= w_rx_pull;
            if (w_tx_start)     r_tx_busy <= 1'b1;
            else if (i_tx_done) r_tx_busy <= 1'b0;
            if (w_timeout) r_lock_err <= 1'b1;
            if ((r_state == RUN) && !i_sync_complete && (r_retrain_cnt != '1))
                r_retrain_cnt <= r_retrain_cnt + RETRAIN_CNT_W'(1);
        end
    end

    assign o_sync_generate = r_sync_generate;
    assign o_tx_start      = r_tx_start;
    assign o_tx_grant      = i_tx_done && r_tx_busy;
    assign o_rx_pull       = r_rx_pull;
    assign o_link_up       = r_link_up;
    assign o_state         = r_state;
    assign o_lock_err      = r_lock_err;
    assign o_retrain_cnt   = r_retrain_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lvds_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_lvds_link_ctrl
// Desc   : Scoreboard bench for lvds_link_ctrl (SYNC_HOLD_CYCLES=8, LOCK_TIMEOUT=20).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_lvds_link_ctrl;
    import lvds_link_pkg::*;

    localparam int SYNC_HOLD = 8;
    localparam int LOCK_TO   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       sync_complete = 1'b0;
    logic       tx_pending = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_available = 1'b0;
    logic       rx_ready = 1'b0;
    logic       sync_generate;
    logic       tx_start;
    logic       tx_grant;
    logic       rx_pull;
    logic       link_up;
    logic [2:0] state;
    logic       lock_err;
    logic [7:0] retrain_cnt;

    int n_checks = 0;
    int n_errors = 0;

    string       tag_q[$];
    logic [31:0] val_q[$];

    lvds_link_ctrl #(
        .SYNC_HOLD_CYCLES (SYNC_HOLD),
        .LOCK_TIMEOUT     (LOCK_TO)
    ) u_dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_enable        (enable),
        .i_sync_complete (sync_complete),
        .o_sync_generate (sync_generate),
        .i_tx_pending    (tx_pending),
        .o_tx_start      (tx_start),
        .i_tx_done       (tx_done),
        .o_tx_grant      (tx_grant),
        .i_rx_available  (rx_available),
        .i_rx_ready      (rx_ready),
        .o_rx_pull       (rx_pull),
        .o_link_up       (link_up),
        .o_state         (state),
        .o_lock_err      (lock_err),
        .o_retrain_cnt   (retrain_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string tag);
        if (tag == "state")   return 32'(state);
        if (tag == "sync")    return 32'(sync_generate);
        if (tag == "link")    return 32'(link_up);
        if (tag == "start")   return 32'(tx_start);
        if (tag == "grant")   return 32'(tx_grant);
        if (tag == "pull")    return 32'(rx_pull);
        if (tag == "lockerr") return 32'(lock_err);
        if (tag == "retrain") return 32'(retrain_cnt);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic sb_drain();
        string       t;
        logic [31:0] v;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            chk(t, observe(t), v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bring_up();
        enable        = 1'b1;
        sync_complete = 1'b1;
        for (int i = 0; i < 40 && !link_up; i++) step();
        chk("bringup", 32'(link_up), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) step();
        push("state", 32'(IDLE)); push("sync", 0); push("link", 0); push("start", 0);
        push("pull", 0); push("lockerr", 0); push("retrain", 0); push("grant", 0);
        sb_drain();
        rst = 1'b0;

        // Bring-up: 5 TRAIN cycles, 8 HOLD cycles, then RUN
        enable = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            sync_complete = (c >= 6);
            step();
            push("state", (c <= 5) ? 32'(TRAIN) : (c <= 13) ? 32'(HOLD) : 32'(RUN));
            push("sync", 32'(c <= 13));
            push("link", 32'(c == 14));
            sb_drain();
        end

        // TX: continuous pending, done two cycles after each start pulse
        tx_pending = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            push("start", 32'(k % 3 == 0));
            tx_done = (k % 3 == 2);
            if (k == 8) tx_pending = 1'b0;
            #1;
            push("grant", 32'(k % 3 == 2));
            sb_drain();
        end
        step();
        push("start", 0);
        sb_drain();
        tx_done = 1'b1;
        #1;
        push("grant", 0);
        sb_drain();
        step();
        tx_done = 1'b0;

        // RX: pulls alternate, none while not ready
        rx_available = 1'b1;
        rx_ready     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            push("pull", 32'(k % 2 == 0));
            sb_drain();
        end
        rx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            push("pull", 0);
            sb_drain();
        end
        rx_available = 1'b0;

        // Lock loss with a transfer in flight goes through DRAIN
        tx_pending = 1'b1;
        step();
        push("start", 1);
        sb_drain();
        tx_pending    = 1'b0;
        sync_complete = 1'b0;
        step();
        push("state", 32'(DRAIN)); push("start", 0); push("retrain", 1); push("link", 0);
        sb_drain();
        step();
        push("state", 32'(DRAIN));
        sb_drain();
        tx_done = 1'b1;
        #1;
        push("grant", 1);
        sb_drain();
        step();
        tx_done = 1'b0;
        push("state", 32'(TRAIN)); push("sync", 1);
        sb_drain();

        // Lock loss and disable together: lock-loss target wins
        bring_up();
        sync_complete = 1'b0;
        enable        = 1'b0;
        step();
        push("state", 32'(TRAIN)); push("retrain", 2);
        sb_drain();
        step();
        push("state", 32'(IDLE)); push("sync", 0);
        sb_drain();

        // Disable alone from RUN
        bring_up();
        enable = 1'b0;
        step();
        push("state", 32'(IDLE)); push("retrain", 2); push("link", 0);
        sb_drain();

        // TRAIN timeout after LOCK_TO cycles, sticky, state unchanged
        sync_complete = 1'b0;
        enable        = 1'b1;
        step();
        push("state", 32'(TRAIN));
        sb_drain();
        for (int j = 1; j <= 45; j++) begin
            step();
            if (j == 19) push("lockerr", 0);
            if (j == 20 || j == 45) begin
                push("lockerr", 1);
                push("state", 32'(TRAIN));
            end
            sb_drain();
        end

        // Asynchronous reset in the middle of HOLD
        sync_complete = 1'b1;
        step();
        step();
        push("state", 32'(HOLD));
        sb_drain();
        #2;
        rst = 1'b1;
        #1;
        push("state", 32'(IDLE)); push("sync", 0); push("link", 0);
        push("lockerr", 0); push("retrain", 0);
        sb_drain();
        step();
        rst = 1'b0;

        // Asynchronous reset in the middle of RUN
        bring_up();
        tx_pending = 1'b1;
        step();
        push("start", 1);
        sb_drain();
        #2;
        rst = 1'b1;
        #1;
        push("state", 32'(IDLE)); push("link", 0); push("start", 0); push("sync", 0);
        sb_drain();
        step();
        rst        = 1'b0;
        tx_pending = 1'b0;

        // Retrain counter saturation
        for (int n = 1; n <= 257; n++) begin
            bring_up();
            sync_complete = 1'b0;
            step();
            if (n == 254) begin
                push("retrain", 254);
                sb_drain();
            end
        end
        push("retrain", 255);
        push("state", 32'(TRAIN));
        sb_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
